// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the RV32I instruction memory.
//
// The loader takes a byte stream with this layout:
//   - a 32-bit little-endian word count N
//   - N little-endian instruction words
// Each assembled word is written to consecutive word addresses starting at BASE.
// The core is held in reset until the last word is committed.
//
// Parameters
//   ADDR_W   word-address width of instruction memory (DEPTH = 2**ADDR_W)
//   BASE     byte address of the first written word (4-byte aligned)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset; aborts any load in progress
//   in_valid  in_byte is valid this cycle
//   in_byte   stream byte
//   in_ready  loader accepts a byte this cycle (registered)
//   we        instruction memory write strobe, one-cycle pulse per word
//   waddr     byte address of the write (BASE + 4*index)
//   wdata     instruction word to write
//   core_rst  holds the core in reset until the image is fully written
//   done      image loaded; sticky until rst
//   err       word count exceeds DEPTH; sticky until rst
module imem_loader #(
    parameter int          ADDR_W = 10,
    parameter logic [31:0] BASE   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    // One bit wider than 32 so that the comparison N > DEPTH stays exact.
    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_LEN,
        S_LOAD,
        S_LAST,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        byte_cnt_reg, byte_cnt_next;
    logic [31:0]       count_reg, count_next;
    logic [23:0]       buf_reg, buf_next;
    logic [ADDR_W:0]   index_reg, index_next;
    logic              in_ready_reg, in_ready_next;
    logic              we_reg, we_next;
    logic [31:0]       waddr_reg, waddr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic              core_rst_reg, core_rst_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic              accept;
    logic [31:0]       full_count;
    logic [31:0]       index_ext;

    assign accept     = in_valid && in_ready_reg;
    // The 4th length byte completes N combinationally.
    // This lets the branch decision happen on the accepting edge.
    assign full_count = {in_byte, count_reg[23:0]};
    assign index_ext  = 32'(index_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_LEN;
            byte_cnt_reg <= '0;
            count_reg    <= '0;
            buf_reg      <= '0;
            index_reg    <= '0;
            in_ready_reg <= 1'b0;
            we_reg       <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            core_rst_reg <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            count_reg    <= count_next;
            buf_reg      <= buf_next;
            index_reg    <= index_next;
            in_ready_reg <= in_ready_next;
            we_reg       <= we_next;
            waddr_reg    <= waddr_next;
            wdata_reg    <= wdata_next;
            core_rst_reg <= core_rst_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        count_next    = count_reg;
        buf_next      = buf_reg;
        index_next    = index_reg;
        we_next       = 1'b0;
        waddr_next    = waddr_reg;
        wdata_next    = wdata_reg;

        case (state_reg)
            S_LEN: begin
                if (accept) begin
                    // The 2-bit byte counter wraps to 0 after the 4th byte.
                    // It therefore starts aligned for the first word.
                    byte_cnt_next                         = byte_cnt_reg + 2'd1;
                    count_next[{byte_cnt_reg, 3'b000} +: 8] = in_byte;
                    if (byte_cnt_reg == 2'd3) begin
                        index_next = '0;
                        if (full_count == 32'd0) begin
                            state_next = S_DONE;
                        end else if ({1'b0, full_count} > DEPTH) begin
                            state_next = S_ERR;
                        end else begin
                            state_next = S_LOAD;
                        end
                    end
                end
            end

            S_LOAD: begin
                if (accept) begin
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    case (byte_cnt_reg)
                        2'd0: buf_next[7:0]   = in_byte;
                        2'd1: buf_next[15:8]  = in_byte;
                        2'd2: buf_next[23:16] = in_byte;
                        default: begin
                            we_next    = 1'b1;
                            wdata_next = {in_byte, buf_reg};
                            waddr_next = BASE + (index_ext << 2);
                            index_next = index_reg + 1'b1;
                            if (index_ext + 32'd1 == count_reg) begin
                                state_next = S_LAST;
                            end
                        end
                    endcase
                end
            end

            // This cycle carries the final write pulse.
            // DONE follows, so the core leaves reset only after that write commits.
            S_LAST:  state_next = S_DONE;
            S_DONE:  state_next = S_DONE;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_LEN;
        endcase
    end

    // Status outputs are registered from the next state.
    // They change on the same edge as the state transition.
    always_comb begin
        in_ready_next = (state_next == S_LEN) || (state_next == S_LOAD);
        done_next     = (state_next == S_DONE);
        err_next      = (state_next == S_ERR);
        core_rst_next = (state_next != S_DONE);
    end

    assign in_ready = in_ready_reg;
    assign we       = we_reg;
    assign waddr    = waddr_reg;
    assign wdata    = wdata_reg;
    assign core_rst = core_rst_reg;
    assign done     = done_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
// The three instances share one stimulus stream:
//   - default parameters
//   - ADDR_W=2 for the overflow and exact-fill cases
//   - BASE=32'h100
// The instance under test is chosen with sel; only its outputs are checked.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_byte;

    logic        rdy_m, we_m, crst_m, done_m, err_m;
    logic [31:0] waddr_m, wdata_m;
    logic        rdy_s, we_s, crst_s, done_s, err_s;
    logic [31:0] waddr_s, wdata_s;
    logic        rdy_b, we_b, crst_b, done_b, err_b;
    logic [31:0] waddr_b, wdata_b;

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    logic [63:0] q_m[$];
    logic [63:0] q_s[$];
    logic [63:0] q_b[$];

    always #5 clk = ~clk;

    imem_loader u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(rdy_m), .we(we_m), .waddr(waddr_m), .wdata(wdata_m),
        .core_rst(crst_m), .done(done_m), .err(err_m)
    );

    imem_loader #(.ADDR_W(2)) u_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(rdy_s), .we(we_s), .waddr(waddr_s), .wdata(wdata_s),
        .core_rst(crst_s), .done(done_s), .err(err_s)
    );

    imem_loader #(.BASE(32'h100)) u_base (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(rdy_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
        .core_rst(crst_b), .done(done_b), .err(err_b)
    );

    // Write monitors sample 1 time unit after the active edge.
    // This keeps them clear of the negedge-driven stimulus.
    always @(posedge clk) begin
        #1;
        if (we_m) begin
            q_m.push_back({waddr_m, wdata_m});
            if (sel == 0) $display("write main  addr=%h data=%h", waddr_m, wdata_m);
        end
        if (we_s) begin
            q_s.push_back({waddr_s, wdata_s});
            if (sel == 1) $display("write small addr=%h data=%h", waddr_s, wdata_s);
        end
        if (we_b) begin
            q_b.push_back({waddr_b, wdata_b});
            if (sel == 2) $display("write base  addr=%h data=%h", waddr_b, wdata_b);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_ready();
        case (sel)
            0:       return rdy_m;
            1:       return rdy_s;
            default: return rdy_b;
        endcase
    endfunction

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Present a byte and return at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        while (!cur_ready() && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", {63'd0, cur_ready()}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (gap > 0) idle(gap + (($urandom_range(0, 3) == 0) ? 2 : 0));
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q_m.delete();
        q_s.delete();
        q_b.delete();
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        @(negedge clk);
        @(negedge clk);

        // Reset values
        check("rst_in_ready", {63'd0, rdy_m}, 64'd0);
        check("rst_we",       {63'd0, we_m},  64'd0);
        check("rst_waddr",    {32'd0, waddr_m}, 64'd0);
        check("rst_wdata",    {32'd0, wdata_m}, 64'd0);
        check("rst_done",     {63'd0, done_m}, 64'd0);
        check("rst_err",      {63'd0, err_m},  64'd0);
        check("rst_core_rst", {63'd0, crst_m}, 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {63'd0, rdy_m}, 64'd1);

        // Basic load, back-to-back
        sel = 0;
        send_word(32'd2, 0);
        send_word(32'h00500513, 0);
        check("basic_w0_count", 64'(q_m.size()), 64'd1);
        send_word(32'h00a00593, 0);
        check("basic_last_we",    {63'd0, we_m},   64'd1);
        check("basic_last_ready", {63'd0, rdy_m},  64'd0);
        check("basic_last_done",  {63'd0, done_m}, 64'd0);
        check("basic_last_crst",  {63'd0, crst_m}, 64'd1);
        @(negedge clk);
        check("basic_done",     {63'd0, done_m}, 64'd1);
        check("basic_core_rst", {63'd0, crst_m}, 64'd0);
        check("basic_we_low",   {63'd0, we_m},   64'd0);
        check("basic_err",      {63'd0, err_m},  64'd0);
        check("basic_nwrites",  64'(q_m.size()), 64'd2);
        check("basic_write0",   q_m[0], {32'h0, 32'h00500513});
        check("basic_write1",   q_m[1], {32'h4, 32'h00a00593});
        check("basic_hold_addr", {32'd0, waddr_m}, 64'h4);
        check("basic_hold_data", {32'd0, wdata_m}, 64'h00a00593);

        // Gapped stream, then bytes offered after completion
        do_reset();
        send_word(32'd2, 1);
        send_word(32'h00500513, 1);
        send_word(32'h00a00593, 1);
        idle(4);
        check("gap_done",    {63'd0, done_m}, 64'd1);
        check("gap_nwrites", 64'(q_m.size()), 64'd2);
        check("gap_write0",  q_m[0], {32'h0, 32'h00500513});
        check("gap_write1",  q_m[1], {32'h4, 32'h00a00593});
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_byte = 8'(8'hA0 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("post_done_nwrites", 64'(q_m.size()), 64'd2);
        check("post_done_ready",   {63'd0, rdy_m},  64'd0);
        check("post_done_done",    {63'd0, done_m}, 64'd1);

        // Zero length
        do_reset();
        send_word(32'd0, 0);
        check("zero_done",  {63'd0, done_m}, 64'd1);
        check("zero_crst",  {63'd0, crst_m}, 64'd0);
        check("zero_ready", {63'd0, rdy_m},  64'd0);
        check("zero_we",    {63'd0, we_m},   64'd0);
        idle(3);
        check("zero_nwrites", 64'(q_m.size()), 64'd0);

        // Overflow on ADDR_W=2
        sel = 1;
        do_reset();
        send_word(32'd5, 0);
        check("ovf_err",   {63'd0, err_s},  64'd1);
        check("ovf_ready", {63'd0, rdy_s},  64'd0);
        check("ovf_crst",  {63'd0, crst_s}, 64'd1);
        check("ovf_done",  {63'd0, done_s}, 64'd0);
        in_valid = 1'b1;
        in_byte  = 8'h55;
        idle(0);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        idle(2);
        check("ovf_err_sticky", {63'd0, err_s}, 64'd1);
        check("ovf_nwrites",    64'(q_s.size()), 64'd0);

        // Exact fill on ADDR_W=2
        do_reset();
        send_word(32'd4, 0);
        for (int i = 0; i < 4; i++) send_word(32'h11111111 * (i + 1), 0);
        @(negedge clk);
        check("fill_done",    {63'd0, done_s}, 64'd1);
        check("fill_err",     {63'd0, err_s},  64'd0);
        check("fill_nwrites", 64'(q_s.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check("fill_write", q_s[i], {32'(4 * i), 32'(32'h11111111 * (i + 1))});

        // Reset mid-word
        sel = 0;
        do_reset();
        send_word(32'd2, 0);
        send_word(32'h00500513, 0);
        send_byte(8'h93);
        send_byte(8'h05);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", {63'd0, rdy_m}, 64'd0);
        check("midrst_we",    {63'd0, we_m},  64'd0);
        rst = 1'b0;
        idle(3);
        check("midrst_nwrites", 64'(q_m.size()), 64'd1);
        check("midrst_done",    {63'd0, done_m}, 64'd0);
        check("midrst_crst",    {63'd0, crst_m}, 64'd1);

        // Full resend after the abort
        do_reset();
        send_word(32'd2, 0);
        send_word(32'h00500513, 0);
        send_word(32'h00a00593, 0);
        @(negedge clk);
        check("resend_done",   {63'd0, done_m}, 64'd1);
        check("resend_write0", q_m[0], {32'h0, 32'h00500513});
        check("resend_write1", q_m[1], {32'h4, 32'h00a00593});

        // BASE = 0x100
        sel = 2;
        do_reset();
        send_word(32'd1, 0);
        send_word(32'hdeadbeef, 0);
        @(negedge clk);
        check("base_nwrites", 64'(q_b.size()), 64'd1);
        check("base_write",   q_b[0], {32'h100, 32'hdeadbeef});
        check("base_done",    {63'd0, done_b}, 64'd1);
        check("base_crst",    {63'd0, crst_b}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
